demod_fir_scheduler: RTL and testbench

DEMOD_FIR_SCHEDULER -- requirements
Module: demod_fir_scheduler

---
 rtl/demod_fir_scheduler.sv | 182 ++++++++++++++++++
 tb/tb_demod_fir_scheduler.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/demod_fir_scheduler.sv
// demod_fir_scheduler
//   Sequences one shared MAC across NUM_CH FIR channels per input sample.
//   On tick_i the new sample is written to the history RAMs (WRITE). Then
//   NUM_TAPS taps are run for each channel back to back (MAC). The MAC
//   pipeline is then drained (DRAIN) and the write pointer advances.
// Ports:
//   clk_i, reset_i         clock, async active-high reset
//   tick_i                 new-sample strobe
//   clr_overrun_i          clears the sticky overrun flag
//   wr_en_o, wr_addr_o     history write strobe / address (ptr)
//   ch_o, rd_addr_o        channel and history read address driven to the MAC
//   coef_addr_o            coefficient ROM address (tap index k)
//   mac_en_o, mac_clr_o    MAC accumulate / load-product controls
//   res_valid_o, res_ch_o  accumulator result valid and its channel
//   busy_o, done_o         sequence active / all channels finished pulse
//   overrun_o              sticky: tick arrived while busy
module demod_fir_scheduler #(
    parameter int NUM_TAPS    = 41,
    parameter int NUM_CH      = 4,
    parameter int ADDR_W      = 6,
    parameter int MAC_LATENCY = 2,
    localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              tick_i,
    input  logic              clr_overrun_i,
    output logic              wr_en_o,
    output logic [ADDR_W-1:0] wr_addr_o,
    output logic [CH_W-1:0]   ch_o,
    output logic [ADDR_W-1:0] rd_addr_o,
    output logic [ADDR_W-1:0] coef_addr_o,
    output logic              mac_en_o,
    output logic              mac_clr_o,
    output logic              res_valid_o,
    output logic [CH_W-1:0]   res_ch_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              overrun_o
);

    localparam int DRN_W    = (MAC_LATENCY > 1) ? $clog2(MAC_LATENCY) : 1;
    localparam int DRN_LAST = (MAC_LATENCY > 0) ? MAC_LATENCY - 1 : 0;
    localparam logic [ADDR_W-1:0] TAP_LAST = ADDR_W'(NUM_TAPS - 1);
    localparam logic [CH_W-1:0]   CH_LAST  = CH_W'(NUM_CH - 1);

    typedef enum logic [1:0] {S_IDLE, S_WRITE, S_MAC, S_DRAIN} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [ADDR_W-1:0] k_q, k_d;
    logic [ADDR_W-1:0] rd_q, rd_d;
    logic [CH_W-1:0]   ch_q, ch_d;
    logic [DRN_W-1:0]  drn_q, drn_d;
    logic              overrun_q, overrun_d;
    logic              last_tap;
    logic [ADDR_W-1:0] ptr_nxt;

    assign last_tap = (state_q == S_MAC) && (k_q == TAP_LAST);
    assign ptr_nxt  = (ptr_q == TAP_LAST) ? '0 : ptr_q + ADDR_W'(1);

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        k_d       = k_q;
        rd_d      = rd_q;
        ch_d      = ch_q;
        drn_d     = '0;
        wr_en_o   = 1'b0;
        mac_en_o  = 1'b0;
        mac_clr_o = 1'b0;
        case (state_q)
            S_IDLE: if (tick_i) state_d = S_WRITE;
            S_WRITE: begin
                wr_en_o = 1'b1;
                state_d = S_MAC;
                k_d     = '0;
                ch_d    = '0;
                rd_d    = ptr_q;
            end
            S_MAC: begin
                mac_en_o  = 1'b1;
                mac_clr_o = (k_q == '0);
                if (k_q == TAP_LAST) begin
                    if (ch_q == CH_LAST) begin
                        // k/ch/rd are left untouched so the MAC-side
                        // addresses hold their final value while idle.
                        if (MAC_LATENCY == 0) begin
                            state_d = S_IDLE;
                            ptr_d   = ptr_nxt;
                        end else begin
                            state_d = S_DRAIN;
                        end
                    end else begin
                        k_d  = '0;
                        ch_d = ch_q + CH_W'(1);
                        rd_d = ptr_q;
                    end
                end else begin
                    k_d  = k_q + ADDR_W'(1);
                    // rd tracks (ptr - k) mod NUM_TAPS incrementally
                    rd_d = (rd_q == '0) ? TAP_LAST : rd_q - ADDR_W'(1);
                end
            end
            S_DRAIN: begin
                drn_d = drn_q + DRN_W'(1);
                if (drn_q == DRN_W'(DRN_LAST)) begin
                    state_d = S_IDLE;
                    ptr_d   = ptr_nxt;
                    drn_d   = '0;
                end
            end
            default: state_d = S_IDLE;
        endcase
        // a fresh overrun beats a simultaneous clear
        overrun_d = (tick_i && state_q != S_IDLE) ? 1'b1 :
                    (clr_overrun_i ? 1'b0 : overrun_q);
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q   <= S_IDLE;
            ptr_q     <= '0;
            k_q       <= '0;
            rd_q      <= '0;
            ch_q      <= '0;
            drn_q     <= '0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            k_q       <= k_d;
            rd_q      <= rd_d;
            ch_q      <= ch_d;
            drn_q     <= drn_d;
            overrun_q <= overrun_d;
        end
    end

    // Result delay line: the last-tap marker and its channel ride alongside
    // the MAC pipeline so res_valid_o lines up with the accumulator output.
    if (MAC_LATENCY == 0) begin : g_nodl
        assign res_valid_o = last_tap;
        assign res_ch_o    = ch_q;
    end else begin : g_dl
        logic [MAC_LATENCY-1:0]           vld_q, vld_d;
        logic [MAC_LATENCY-1:0][CH_W-1:0] rch_q, rch_d;

        always_comb begin
            vld_d    = vld_q;
            rch_d    = rch_q;
            vld_d[0] = last_tap;
            rch_d[0] = ch_q;
            for (int i = 1; i < MAC_LATENCY; i++) begin
                vld_d[i] = vld_q[i-1];
                rch_d[i] = rch_q[i-1];
            end
        end

        always_ff @(posedge clk_i or posedge reset_i) begin
            if (reset_i) begin
                vld_q <= '0;
                rch_q <= '0;
            end else begin
                vld_q <= vld_d;
                rch_q <= rch_d;
            end
        end

        assign res_valid_o = vld_q[MAC_LATENCY-1];
        assign res_ch_o    = rch_q[MAC_LATENCY-1];
    end

    assign done_o      = res_valid_o && (res_ch_o == CH_LAST);
    assign busy_o      = (state_q != S_IDLE);
    assign overrun_o   = overrun_q;
    assign wr_addr_o   = ptr_q;
    assign ch_o        = ch_q;
    assign rd_addr_o   = rd_q;
    assign coef_addr_o = k_q;

endmodule

// File: tb/tb_demod_fir_scheduler.sv
// Bench for demod_fir_scheduler: a default build (41 taps, 4 ch, latency 2)
// and a minimal build (5 taps, 1 ch, latency 0) share the same stimulus.
// Each is compared every cycle against a timeline model indexed by the
// cycle offset within the current sequence.
module tb_demod_fir_scheduler;
    logic clk = 1'b0, reset_i = 1'b1, tick_i = 1'b0, clr_overrun_i = 1'b0;
    always #5 clk = ~clk;

    logic       a_wr_en, a_mac_en, a_mac_clr, a_rv, a_busy, a_done, a_ov;
    logic [5:0] a_wr_addr, a_rd, a_coef;
    logic [1:0] a_ch, a_rch;
    logic       b_wr_en, b_mac_en, b_mac_clr, b_rv, b_busy, b_done, b_ov;
    logic [2:0] b_wr_addr, b_rd, b_coef;
    logic [0:0] b_ch, b_rch;

    demod_fir_scheduler dut_a (
        .clk_i(clk), .reset_i(reset_i), .tick_i(tick_i), .clr_overrun_i(clr_overrun_i),
        .wr_en_o(a_wr_en), .wr_addr_o(a_wr_addr), .ch_o(a_ch), .rd_addr_o(a_rd),
        .coef_addr_o(a_coef), .mac_en_o(a_mac_en), .mac_clr_o(a_mac_clr),
        .res_valid_o(a_rv), .res_ch_o(a_rch), .busy_o(a_busy), .done_o(a_done),
        .overrun_o(a_ov));

    demod_fir_scheduler #(.NUM_TAPS(5), .NUM_CH(1), .ADDR_W(3), .MAC_LATENCY(0)) dut_b (
        .clk_i(clk), .reset_i(reset_i), .tick_i(tick_i), .clr_overrun_i(clr_overrun_i),
        .wr_en_o(b_wr_en), .wr_addr_o(b_wr_addr), .ch_o(b_ch), .rd_addr_o(b_rd),
        .coef_addr_o(b_coef), .mac_en_o(b_mac_en), .mac_clr_o(b_mac_clr),
        .res_valid_o(b_rv), .res_ch_o(b_rch), .busy_o(b_busy), .done_o(b_done),
        .overrun_o(b_ov));

    int tests = 0, fails = 0;
    int NT[2]  = '{41, 5};
    int NC[2]  = '{4, 1};
    int LAT[2] = '{2, 0};
    // model state per build
    bit act[2];
    int n[2], ptr_m[2], hk[2], hch[2], hrd[2];
    bit ov_m[2];
    bit in_rst = 1'b0;

    task automatic chk(input string tag, input int d, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s dut%0d observed=%0d expected=%0d", tag, d, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            act[d] = 0; n[d] = 0; ptr_m[d] = 0; ov_m[d] = 0;
            hk[d] = 0; hch[d] = 0; hrd[d] = 0;
        end
    endtask

    // advance the model across one rising edge with the given inputs
    task automatic model_edge(input bit t, input bit c);
        for (int d = 0; d < 2; d++) begin
            bit was_busy;
            int total;
            was_busy = act[d];
            total = 1 + NC[d] * NT[d] + LAT[d];
            if (act[d]) begin
                if (n[d] == total) begin
                    act[d] = 0;
                    ptr_m[d] = (ptr_m[d] + 1) % NT[d];
                end else n[d]++;
            end else if (t) begin
                act[d] = 1; n[d] = 1;
            end
            if (t && was_busy) ov_m[d] = 1;
            else if (c) ov_m[d] = 0;
        end
    endtask

    task automatic check_all();
        for (int d = 0; d < 2; d++) begin
            int nt, nc, lat, m, r, k;
            int e_wr, e_mac, e_clr, e_rv, e_rch, e_done, e_busy;
            logic [31:0] g_wr, g_wa, g_ch, g_rd, g_cf, g_mac, g_clr, g_rv, g_rch, g_busy, g_done, g_ov;
            nt = NT[d]; nc = NC[d]; lat = LAT[d];
            e_wr = 0; e_mac = 0; e_clr = 0; e_rv = 0; e_rch = 0; e_done = 0; e_busy = 0;
            if (act[d]) begin
                e_busy = 1;
                e_wr = (n[d] == 1);
                m = n[d] - 2;
                if (m >= 0 && m < nc * nt) begin
                    e_mac = 1;
                    k = m % nt;
                    hk[d] = k; hch[d] = m / nt;
                    hrd[d] = (ptr_m[d] - k + nt) % nt;
                    e_clr = (k == 0);
                end
                r = n[d] - 1 - lat;
                if (r > 0 && r % nt == 0 && r / nt <= nc) begin
                    e_rv = 1; e_rch = r / nt - 1; e_done = (e_rch == nc - 1);
                end
            end
            if (d == 0) begin
                g_wr = a_wr_en; g_wa = a_wr_addr; g_ch = a_ch; g_rd = a_rd; g_cf = a_coef;
                g_mac = a_mac_en; g_clr = a_mac_clr; g_rv = a_rv; g_rch = a_rch;
                g_busy = a_busy; g_done = a_done; g_ov = a_ov;
            end else begin
                g_wr = b_wr_en; g_wa = b_wr_addr; g_ch = b_ch; g_rd = b_rd; g_cf = b_coef;
                g_mac = b_mac_en; g_clr = b_mac_clr; g_rv = b_rv; g_rch = b_rch;
                g_busy = b_busy; g_done = b_done; g_ov = b_ov;
            end
            chk("wr_en", d, g_wr, e_wr);
            chk("wr_addr", d, g_wa, ptr_m[d]);
            chk("mac_en", d, g_mac, e_mac);
            chk("mac_clr", d, g_clr, e_clr);
            chk("ch", d, g_ch, hch[d]);
            chk("rd_addr", d, g_rd, hrd[d]);
            chk("coef_addr", d, g_cf, hk[d]);
            chk("res_valid", d, g_rv, e_rv);
            if (e_rv || in_rst) chk("res_ch", d, g_rch, e_rch);
            chk("busy", d, g_busy, e_busy);
            chk("done", d, g_done, e_done);
            chk("overrun", d, g_ov, ov_m[d]);
        end
    endtask

    // one clock: drive inputs (called just after a falling edge), step the
    // model over the rising edge, compare on the next falling edge
    task automatic cyc(input bit t, input bit c);
        tick_i = t; clr_overrun_i = c;
        @(posedge clk);
        model_edge(t, c);
        #1 tick_i = 1'b0; clr_overrun_i = 1'b0;
        @(negedge clk);
        check_all();
    endtask

    initial begin
        model_reset();
        repeat (2) @(negedge clk);
        in_rst = 1'b1;
        check_all();
        in_rst = 1'b0;
        reset_i = 1'b0;

        // single sequence after reset
        cyc(1, 0);
        repeat (180) cyc(0, 0);

        // 42 well-spaced ticks: pointer walks and wraps, no overrun
        for (int i = 0; i < 42; i++) begin
            cyc(1, 0);
            repeat (199) cyc(0, 0);
        end

        // tick at cycle 100 and on the done cycle of the default build
        cyc(1, 0);
        repeat (99) cyc(0, 0);
        cyc(1, 0);
        repeat (66) cyc(0, 0);
        cyc(1, 0);
        repeat (10) cyc(0, 0);
        cyc(0, 1);
        cyc(1, 0);
        repeat (180) cyc(0, 0);

        // reset mid-sequence at cycle 60
        cyc(1, 0);
        repeat (59) cyc(0, 0);
        @(posedge clk);
        #2 reset_i = 1'b1;
        model_reset();
        #1 in_rst = 1'b1;
        check_all();
        in_rst = 1'b0;
        @(negedge clk);
        reset_i = 1'b0;
        repeat (200) cyc(0, 0);
        cyc(1, 0);
        repeat (180) cyc(0, 0);

        // random ticks and clears, including clear/set collisions
        for (int i = 0; i < 3000; i++)
            cyc(($urandom % 60) == 0, ($urandom % 100) == 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
